// File: rtl/core_ex_mdu_if.sv
// EX-stage bundle: ID/EX operands and controls, MEM/WB forwarding taps, and EX results.
// master = pipeline side driving the stage, slave = the execute stage itself.
interface core_ex_mdu_if #(
  parameter int DATA_W = 32,
  parameter int SH_W   = 5,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              flush;
  logic [4:0]        ex_op;
  logic [1:0]        alusrc;
  logic              shamt_var;
  logic [SH_W-1:0]   shamt;
  logic [15:0]       imm16;
  logic              regdst;
  logic [REG_AW-1:0] id_ex_rs;
  logic [REG_AW-1:0] id_ex_rt;
  logic [REG_AW-1:0] id_ex_rd;
  logic [DATA_W-1:0] alusrc_a;
  logic [DATA_W-1:0] alusrc_b;
  logic              mem_regwrite;
  logic              wb_regwrite;
  logic [REG_AW-1:0] mem_regrd;
  logic [REG_AW-1:0] wb_regrd;
  logic [DATA_W-1:0] mem_reg_data;
  logic [DATA_W-1:0] wb_reg_data;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] data_to_mem;
  logic [REG_AW-1:0] ex_dest_rd;
  logic              zero;
  logic              ex_stall;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output in_valid, flush, ex_op, alusrc, shamt_var, shamt, imm16, regdst,
           id_ex_rs, id_ex_rt, id_ex_rd, alusrc_a, alusrc_b,
           mem_regwrite, wb_regwrite, mem_regrd, wb_regrd, mem_reg_data, wb_reg_data,
    input  alu_result, data_to_mem, ex_dest_rd, zero, ex_stall, hi, lo
  );

  modport slave (
    input  in_valid, flush, ex_op, alusrc, shamt_var, shamt, imm16, regdst,
           id_ex_rs, id_ex_rt, id_ex_rd, alusrc_a, alusrc_b,
           mem_regwrite, wb_regwrite, mem_regrd, wb_regrd, mem_reg_data, wb_reg_data,
    output alu_result, data_to_mem, ex_dest_rd, zero, ex_stall, hi, lo
  );
endinterface

// File: rtl/core_ex_mdu.sv
// Execute stage: forwarding, ALU, dest select, plus iterative multiply/divide with HI/LO.
// Optional macro CORE_EX_DIV0_FAST_EN: divide-by-zero completes in the issue cycle.
module core_ex_mdu #(
  parameter int DATA_W = 32,
  parameter int SH_W   = 5,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  core_ex_mdu_if.slave  ex
);
  localparam int MSB = DATA_W - 1;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd12;
  localparam logic [4:0] OP_MULTU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_MFHI  = 5'd16;
  localparam logic [4:0] OP_MFLO  = 5'd17;
  localparam logic [4:0] OP_MTHI  = 5'd18;
  localparam logic [4:0] OP_MTLO  = 5'd19;

  localparam logic [SH_W-1:0] CNT_ONE  = SH_W'(1);
  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_W - 1);

  // imm16 handling needs at least 16 datapath bits
  if ((DATA_W < 16) || (SH_W != $clog2(DATA_W)) || ((1 << SH_W) != DATA_W)) begin : g_bad_param
    $error("core_ex_mdu: DATA_W must be a power of two >= 16 and SH_W = log2(DATA_W)");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   cnt_q;
  logic [DATA_W-1:0] acc_q, rq_q, b_q, dvd_q;
  logic              div_q, neg_q, rneg_q, div0_q;
  logic [DATA_W-1:0] hi_q, lo_q;

  logic              fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb;
  logic [DATA_W-1:0] src1, src2, opb, alu_res;
  logic [SH_W-1:0]   sh_amt;

  // ---------------- forwarding and operand select ----------------
  assign fwd_a_mem = ex.mem_regwrite && (ex.mem_regrd != '0) && (ex.mem_regrd == ex.id_ex_rs);
  assign fwd_a_wb  = ex.wb_regwrite  && (ex.wb_regrd  != '0) && (ex.wb_regrd  == ex.id_ex_rs);
  assign fwd_b_mem = ex.mem_regwrite && (ex.mem_regrd != '0) && (ex.mem_regrd == ex.id_ex_rt);
  assign fwd_b_wb  = ex.wb_regwrite  && (ex.wb_regrd  != '0) && (ex.wb_regrd  == ex.id_ex_rt);

  always_comb begin
    src1 = ex.alusrc_a;
    if (fwd_a_mem)     src1 = ex.mem_reg_data;
    else if (fwd_a_wb) src1 = ex.wb_reg_data;
    src2 = ex.alusrc_b;
    if (fwd_b_mem)     src2 = ex.mem_reg_data;
    else if (fwd_b_wb) src2 = ex.wb_reg_data;
  end

  always_comb begin
    case (ex.alusrc)
      2'd1:    opb = {{(DATA_W-16){ex.imm16[15]}}, ex.imm16};
      2'd2:    opb = {{(DATA_W-16){1'b0}}, ex.imm16};
      default: opb = src2;
    endcase
  end

  assign sh_amt = ex.shamt_var ? src1[SH_W-1:0] : ex.shamt;

  // ---------------- ALU ----------------
  always_comb begin
    alu_res = '0;
    case (ex.ex_op)
      OP_ADD:  alu_res = src1 + opb;
      OP_SUB:  alu_res = src1 - opb;
      OP_AND:  alu_res = src1 & opb;
      OP_OR:   alu_res = src1 | opb;
      OP_XOR:  alu_res = src1 ^ opb;
      OP_NOR:  alu_res = ~(src1 | opb);
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1) < $signed(opb))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (src1 < opb)};
      OP_SLL:  alu_res = opb << sh_amt;
      OP_SRL:  alu_res = opb >> sh_amt;
      OP_SRA:  alu_res = $unsigned($signed(opb) >>> sh_amt);
      OP_LUI:  alu_res = {ex.imm16, {(DATA_W-16){1'b0}}};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign ex.alu_result  = alu_res;
  assign ex.zero        = (ex.ex_op == OP_SUB) && (alu_res == '0);
  assign ex.data_to_mem = src2;
  assign ex.ex_dest_rd  = ex.regdst ? ex.id_ex_rd : ex.id_ex_rt;
  assign ex.hi          = hi_q;
  assign ex.lo          = lo_q;

  // ---------------- MDU issue decode ----------------
  logic              is_mdu, op_signed, op_div, issue, div0_now;
  logic [DATA_W-1:0] mag_a, mag_b;

  assign is_mdu    = (ex.ex_op >= OP_MULT) && (ex.ex_op <= OP_DIVU);
  assign op_signed = (ex.ex_op == OP_MULT) || (ex.ex_op == OP_DIV);
  assign op_div    = (ex.ex_op == OP_DIV)  || (ex.ex_op == OP_DIVU);
  assign issue     = (state_q == S_IDLE) && ex.in_valid && !ex.flush && is_mdu;
  assign div0_now  = op_div && (opb == '0);
  assign mag_a     = (op_signed && src1[MSB]) ? -src1 : src1;
  assign mag_b     = (op_signed && opb[MSB])  ? -opb  : opb;

  // ---------------- MDU control FSM ----------------
  logic finish, ex_stall;
`ifdef CORE_EX_DIV0_FAST_EN
  logic fast_div0;
`endif

  always_comb begin
    state_d  = state_q;
    ex_stall = 1'b0;
    finish   = 1'b0;
`ifdef CORE_EX_DIV0_FAST_EN
    fast_div0 = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          ex_stall = 1'b1;
          state_d  = S_BUSY;
`ifdef CORE_EX_DIV0_FAST_EN
          if (div0_now) begin
            state_d   = S_DONE;
            fast_div0 = 1'b1;
          end
`endif
        end
      end
      S_BUSY: begin
        ex_stall = 1'b1;
        if (ex.flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          finish  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ex.ex_stall = ex_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- MDU datapath: one radix-2 step per BUSY cycle ----------------
  // Multiply: acc:rq is the shifting partial product, rq starts as the multiplier.
  // Divide: acc is the partial remainder, rq shifts the dividend out and the quotient in.
  logic [DATA_W:0]     mul_sum, div_shift, div_trial;
  logic [DATA_W-1:0]   step_acc, step_rq, quot_fix, rem_fix;
  logic [2*DATA_W-1:0] prod_raw, prod_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (rq_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q, rq_q[MSB]};
    div_trial = div_shift - {1'b0, b_q};
    if (!div_q) begin
      step_acc = mul_sum[DATA_W:1];
      step_rq  = {mul_sum[0], rq_q[MSB:1]};
    end else if (!div_trial[DATA_W]) begin
      step_acc = div_trial[DATA_W-1:0];
      step_rq  = {rq_q[MSB-1:0], 1'b1};
    end else begin
      step_acc = div_shift[DATA_W-1:0];
      step_rq  = {rq_q[MSB-1:0], 1'b0};
    end
    prod_raw = {step_acc, step_rq};
    prod_fix = neg_q  ? -prod_raw : prod_raw;
    quot_fix = neg_q  ? -step_rq  : step_rq;
    rem_fix  = rneg_q ? -step_acc : step_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      rq_q   <= '0;
      b_q    <= '0;
      dvd_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      div0_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (issue) begin
        cnt_q  <= '0;
        acc_q  <= '0;
        rq_q   <= mag_a;
        b_q    <= mag_b;
        dvd_q  <= src1;
        div_q  <= op_div;
        neg_q  <= op_signed && (src1[MSB] ^ opb[MSB]);
        rneg_q <= op_signed && src1[MSB];
        div0_q <= div0_now;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q + CNT_ONE;
        acc_q <= step_acc;
        rq_q  <= step_rq;
      end

      if (finish) begin
        if (div_q && div0_q) begin
          hi_q <= dvd_q;
          lo_q <= '1;
        end else if (div_q) begin
          hi_q <= rem_fix;
          lo_q <= quot_fix;
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
`ifdef CORE_EX_DIV0_FAST_EN
      end else if (fast_div0) begin
        hi_q <= src1;
        lo_q <= '1;
`endif
      end else if (ex.in_valid && !ex_stall && !ex.flush) begin
        if (ex.ex_op == OP_MTHI) hi_q <= src1;
        if (ex.ex_op == OP_MTLO) lo_q <= src1;
      end
    end
  end
endmodule
